// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
//   cond_e       : 4-bit B.cond condition codes (EQ..AL, NV)
//   alu_cntrl_e  : 3-bit ALU operation select
package cpu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_HS = 4'b0010,
        COND_LO = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'b000,
        ALU_ADD    = 3'b010,
        ALU_SUB    = 3'b011,
        ALU_AND    = 3'b100,
        ALU_OR     = 3'b101,
        ALU_XOR    = 3'b110
    } alu_cntrl_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator for B.cond.
//   cond       : 4-bit condition code
//   n, z, v, c : flag values to evaluate against
//   taken      : 1 when the condition holds
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       n,
    input  logic       z,
    input  logic       v,
    input  logic       c,
    output logic       taken
);

    always_comb begin
        taken = 1'b1;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_HS: taken = c;
            COND_LO: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c & !z;
            COND_LS: taken = !(c & !z);
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z & (n == v);
            COND_LE: taken = !(!z & (n == v));
            default: taken = 1'b1;   // AL and NV both mean "always"
        endcase
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with the architectural NZVC flag register and
// the EX-stage branch-redirect decisions (B.cond and CBZ).
//   clk, reset       : clock, synchronous active-high reset
//   stall, flush     : hold MEM/flags; insert a bubble into MEM
//   ex_*             : EX-stage instruction, ALU result/flags and controls
//   mem_*            : registered MEM-stage copy of the instruction
//   flag_n/z/v/c     : architectural flag register
//   br_taken         : B.cond redirect (combinational, uses current flags)
//   cbz_taken        : CBZ redirect (combinational, uses ex_zero)
module ex_mem_reg
    import cpu_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic                ex_negative,
    input  logic                ex_zero,
    input  logic                ex_overflow,
    input  logic                ex_carry_out,
    input  logic                ex_set_flags,
    input  logic                ex_reg_write,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic                ex_br_cond,
    input  logic                ex_cbz,
    input  logic [WIDTH-1:0]    ex_result,
    input  logic [WIDTH-1:0]    ex_store_data,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic [3:0]          ex_cond,
    output logic                mem_valid,
    output logic [WIDTH-1:0]    mem_result,
    output logic [WIDTH-1:0]    mem_store_data,
    output logic [REG_BITS-1:0] mem_rd,
    output logic                mem_reg_write,
    output logic                mem_mem_read,
    output logic                mem_mem_write,
    output logic                flag_n,
    output logic                flag_z,
    output logic                flag_v,
    output logic                flag_c,
    output logic                br_taken,
    output logic                cbz_taken
);

    logic [3:0] flags_reg;      // {N, Z, V, C}
    logic       cond_taken;
    logic       advance;        // the EX instruction really moves forward this edge

    assign advance = ex_valid & !stall & !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            flags_reg      <= 4'b0000;
        end else if (flush) begin
            // Bubble: only the valid bit and controls matter; data is left alone.
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            mem_reg_write  <= ex_reg_write & ex_valid;
            mem_mem_read   <= ex_mem_read  & ex_valid;
            mem_mem_write  <= ex_mem_write & ex_valid;
            if (ex_valid && ex_set_flags) begin
                flags_reg <= {ex_negative, ex_zero, ex_overflow, ex_carry_out};
            end
        end
    end

    assign flag_n = flags_reg[3];
    assign flag_z = flags_reg[2];
    assign flag_v = flags_reg[1];
    assign flag_c = flags_reg[0];

    // B.cond reads the registered flags, so a flag-setter in EX this cycle
    // only influences branches from the next cycle on.
    cond_eval u_cond_eval (
        .cond  (ex_cond),
        .n     (flags_reg[3]),
        .z     (flags_reg[2]),
        .v     (flags_reg[1]),
        .c     (flags_reg[0]),
        .taken (cond_taken)
    );

    assign br_taken  = advance & ex_br_cond & cond_taken;
    assign cbz_taken = advance & ex_cbz & ex_zero;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

    localparam int WIDTH    = 64;
    localparam int REG_BITS = 5;

    logic                clk = 1'b0;
    logic                reset, stall, flush, ex_valid;
    logic                ex_negative, ex_zero, ex_overflow, ex_carry_out;
    logic                ex_set_flags, ex_reg_write, ex_mem_read, ex_mem_write;
    logic                ex_br_cond, ex_cbz;
    logic [WIDTH-1:0]    ex_result, ex_store_data;
    logic [REG_BITS-1:0] ex_rd;
    logic [3:0]          ex_cond;
    logic                mem_valid;
    logic [WIDTH-1:0]    mem_result, mem_store_data;
    logic [REG_BITS-1:0] mem_rd;
    logic                mem_reg_write, mem_mem_read, mem_mem_write;
    logic                flag_n, flag_z, flag_v, flag_c;
    logic                br_taken, cbz_taken;

    int vec_count  = 0;
    int miss_count = 0;

    always #5 clk = ~clk;

    ex_mem_reg #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_negative(ex_negative), .ex_zero(ex_zero),
        .ex_overflow(ex_overflow), .ex_carry_out(ex_carry_out),
        .ex_set_flags(ex_set_flags), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_br_cond(ex_br_cond), .ex_cbz(ex_cbz),
        .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_cond(ex_cond),
        .mem_valid(mem_valid), .mem_result(mem_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c),
        .br_taken(br_taken), .cbz_taken(cbz_taken)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; ex_valid = 0;
        ex_negative = 0; ex_zero = 0; ex_overflow = 0; ex_carry_out = 0;
        ex_set_flags = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
        ex_br_cond = 0; ex_cbz = 0;
        ex_result = '0; ex_store_data = '0; ex_rd = '0; ex_cond = 4'h0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; stall = 1; ex_valid = 1; ex_reg_write = 1; ex_result = 64'hDEAD;
        tick(); tick();
        idle();
        vec_count++;
        if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write} !== 4'b0000) begin
            miss_count++; $display("FAIL reset_ctrl: got %b expected 0000",
                {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write});
        end
        vec_count++;
        if ({mem_result, mem_store_data, mem_rd} !== '0) begin
            miss_count++; $display("FAIL reset_data: got %h/%h/%h expected 0",
                mem_result, mem_store_data, mem_rd);
        end
        vec_count++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0000) begin
            miss_count++; $display("FAIL reset_flags: got %b expected 0000",
                {flag_n, flag_z, flag_v, flag_c});
        end
        reset = 0;
        $display("test_reset: mem_valid=%b flags=%b", mem_valid, {flag_n, flag_z, flag_v, flag_c});
    endtask

    task automatic test_adds_overflow();
        idle();
        ex_valid = 1; ex_set_flags = 1; ex_reg_write = 1; ex_rd = 5'd2;
        ex_result = 64'h8000_0000_0000_0000;
        ex_negative = 1; ex_zero = 0; ex_overflow = 1; ex_carry_out = 0;
        tick();
        idle();
        vec_count++;
        if (mem_result !== 64'h8000_0000_0000_0000) begin
            miss_count++; $display("FAIL adds_result: got %h expected 8000000000000000", mem_result);
        end
        vec_count++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b1010) begin
            miss_count++; $display("FAIL adds_flags: got %b expected 1010", {flag_n, flag_z, flag_v, flag_c});
        end
        vec_count++;
        if ({mem_valid, mem_reg_write, mem_rd} !== {1'b1, 1'b1, 5'd2}) begin
            miss_count++; $display("FAIL adds_ctrl: got %b/%b/%0d expected 1/1/2",
                mem_valid, mem_reg_write, mem_rd);
        end
        $display("test_adds_overflow: mem_result=%h flags=%b", mem_result, {flag_n, flag_z, flag_v, flag_c});
    endtask

    task automatic test_branch_cond();
        // SUBS 1-1 carrying its own B.cond EQ: must see old Z=0, not the new one
        idle();
        ex_valid = 1; ex_set_flags = 1; ex_reg_write = 1; ex_result = '0;
        ex_zero = 1; ex_carry_out = 1;
        ex_br_cond = 1; ex_cond = 4'b0000;
        #1;
        vec_count++;
        if (br_taken !== 1'b0) begin
            miss_count++; $display("FAIL br_same_cycle: got %b expected 0", br_taken);
        end
        tick();
        idle();
        vec_count++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0101) begin
            miss_count++; $display("FAIL subs_flags: got %b expected 0101", {flag_n, flag_z, flag_v, flag_c});
        end
        ex_valid = 1; ex_br_cond = 1; ex_cond = 4'b0000; #1;
        vec_count++;
        if (br_taken !== 1'b1) begin
            miss_count++; $display("FAIL br_eq: got %b expected 1", br_taken);
        end
        ex_cond = 4'b0001; #1;
        vec_count++;
        if (br_taken !== 1'b0) begin
            miss_count++; $display("FAIL br_ne: got %b expected 0", br_taken);
        end
        ex_cond = 4'b0010; #1;
        vec_count++;
        if (br_taken !== 1'b1) begin
            miss_count++; $display("FAIL br_hs: got %b expected 1", br_taken);
        end
        tick();
        idle();
        $display("test_branch_cond: flags=%b", {flag_n, flag_z, flag_v, flag_c});
    endtask

    task automatic test_stall();
        idle();
        ex_valid = 1; ex_reg_write = 1; ex_rd = 5'd3;
        ex_result = 64'h77; ex_store_data = 64'hAB;
        tick();
        // ADDS with result 5 sits in EX while stalled; flags are 0101
        idle();
        stall = 1; ex_valid = 1; ex_set_flags = 1; ex_result = 64'h5; ex_rd = 5'd9;
        ex_mem_write = 1; ex_negative = 1; ex_zero = 1; ex_overflow = 1; ex_carry_out = 0;
        ex_br_cond = 1; ex_cond = 4'b1110; ex_cbz = 1;
        for (int i = 0; i < 3; i++) begin
            vec_count++;
            if ({br_taken, cbz_taken} !== 2'b00) begin
                miss_count++; $display("FAIL stall_redirect[%0d]: got %b expected 00", i, {br_taken, cbz_taken});
            end
            tick();
            vec_count++;
            if ({mem_valid, mem_reg_write, mem_mem_write, mem_rd, mem_result, mem_store_data}
                    !== {1'b1, 1'b1, 1'b0, 5'd3, 64'h77, 64'hAB}) begin
                miss_count++; $display("FAIL stall_hold[%0d]: got %b%b%b rd=%0d res=%h sd=%h expected 110 rd=3 res=77 sd=ab",
                    i, mem_valid, mem_reg_write, mem_mem_write, mem_rd, mem_result, mem_store_data);
            end
            vec_count++;
            if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0101) begin
                miss_count++; $display("FAIL stall_flags[%0d]: got %b expected 0101", i, {flag_n, flag_z, flag_v, flag_c});
            end
        end
        stall = 0; #1;
        vec_count++;
        if ({br_taken, cbz_taken} !== 2'b11) begin
            miss_count++; $display("FAIL release_redirect: got %b expected 11", {br_taken, cbz_taken});
        end
        tick();
        idle();
        vec_count++;
        if ({mem_result, mem_rd, mem_mem_write} !== {64'h5, 5'd9, 1'b1}) begin
            miss_count++; $display("FAIL release_capture: got res=%h rd=%0d mw=%b expected 5/9/1",
                mem_result, mem_rd, mem_mem_write);
        end
        vec_count++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b1110) begin
            miss_count++; $display("FAIL release_flags: got %b expected 1110", {flag_n, flag_z, flag_v, flag_c});
        end
        $display("test_stall: mem_result=%h flags=%b", mem_result, {flag_n, flag_z, flag_v, flag_c});
    endtask

    task automatic test_flush_stall();
        idle();
        flush = 1; stall = 1; ex_valid = 1; ex_reg_write = 1; ex_mem_write = 1;
        ex_set_flags = 1; ex_zero = 1; ex_carry_out = 1;
        ex_br_cond = 1; ex_cond = 4'b1110; ex_cbz = 1;
        #1;
        vec_count++;
        if ({br_taken, cbz_taken} !== 2'b00) begin
            miss_count++; $display("FAIL flush_redirect: got %b expected 00", {br_taken, cbz_taken});
        end
        tick();
        vec_count++;
        if ({mem_valid, mem_reg_write, mem_mem_write} !== 3'b000) begin
            miss_count++; $display("FAIL flush_stall_ctrl: got %b expected 000",
                {mem_valid, mem_reg_write, mem_mem_write});
        end
        vec_count++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b1110) begin
            miss_count++; $display("FAIL flush_stall_flags: got %b expected 1110", {flag_n, flag_z, flag_v, flag_c});
        end
        stall = 0; ex_mem_read = 1;
        tick();
        idle();
        vec_count++;
        if ({mem_valid, mem_mem_read, flag_n, flag_z, flag_v, flag_c} !== 6'b00_1110) begin
            miss_count++; $display("FAIL flush_only: got %b expected 001110",
                {mem_valid, mem_mem_read, flag_n, flag_z, flag_v, flag_c});
        end
        $display("test_flush_stall: mem_valid=%b flags=%b", mem_valid, {flag_n, flag_z, flag_v, flag_c});
    endtask

    task automatic test_invalid();
        idle();
        ex_valid = 0; ex_set_flags = 1; ex_cbz = 1; ex_zero = 1;
        ex_reg_write = 1; ex_mem_read = 1; ex_br_cond = 1; ex_cond = 4'b1110;
        #1;
        vec_count++;
        if ({br_taken, cbz_taken} !== 2'b00) begin
            miss_count++; $display("FAIL invalid_redirect: got %b expected 00", {br_taken, cbz_taken});
        end
        tick();
        idle();
        vec_count++;
        if ({mem_valid, mem_reg_write, mem_mem_read} !== 3'b000) begin
            miss_count++; $display("FAIL invalid_ctrl: got %b expected 000",
                {mem_valid, mem_reg_write, mem_mem_read});
        end
        vec_count++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b1110) begin
            miss_count++; $display("FAIL invalid_flags: got %b expected 1110", {flag_n, flag_z, flag_v, flag_c});
        end
        $display("test_invalid: mem_valid=%b flags=%b", mem_valid, {flag_n, flag_z, flag_v, flag_c});
    endtask

    task automatic test_cond_table();
        logic [3:0] nzvc [4];
        logic       exp_tab [4][16];
        nzvc = '{4'b1001, 4'b0110, 4'b1010, 4'b0101};
        exp_tab[0] = '{0,1,1,0, 1,0,0,1, 1,0,0,1, 0,1,1,1};
        exp_tab[1] = '{1,0,0,1, 0,1,1,0, 0,1,0,1, 0,1,1,1};
        exp_tab[2] = '{0,1,0,1, 1,0,1,0, 0,1,1,0, 1,0,1,1};
        exp_tab[3] = '{1,0,1,0, 0,1,0,1, 0,1,1,0, 0,1,1,1};
        for (int s = 0; s < 4; s++) begin
            idle();
            ex_valid = 1; ex_set_flags = 1;
            {ex_negative, ex_zero, ex_overflow, ex_carry_out} = nzvc[s];
            tick();
            idle();
            ex_valid = 1; ex_br_cond = 1;
            for (int c = 0; c < 16; c++) begin
                ex_cond = c[3:0];
                #1;
                vec_count++;
                if (br_taken !== exp_tab[s][c]) begin
                    miss_count++; $display("FAIL cond_table nzvc=%b cond=%0d: got %b expected %b",
                        nzvc[s], c, br_taken, exp_tab[s][c]);
                end
                tick();
            end
            $display("test_cond_table: nzvc=%b swept 16 codes", nzvc[s]);
        end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        ex_valid = 1; ex_set_flags = 1;
        {ex_negative, ex_zero, ex_overflow, ex_carry_out} = 4'b1111;
        tick();
        vec_count++;
        if ({flag_n, flag_z, flag_v, flag_c} !== 4'b1111) begin
            miss_count++; $display("FAIL rst_pre_flags: got %b expected 1111", {flag_n, flag_z, flag_v, flag_c});
        end
        idle();
        stall = 1; ex_valid = 1; ex_reg_write = 1; ex_result = 64'h33;
        tick();
        reset = 1;
        tick();
        reset = 0;
        vec_count++;
        if ({flag_n, flag_z, flag_v, flag_c, mem_valid, mem_reg_write} !== 6'b0000_00) begin
            miss_count++; $display("FAIL rst_stall_state: got %b expected 000000",
                {flag_n, flag_z, flag_v, flag_c, mem_valid, mem_reg_write});
        end
        idle();
        ex_valid = 1; ex_br_cond = 1; ex_cond = 4'b1010; ex_reg_write = 1; ex_result = 64'h44;
        #1;
        vec_count++;
        if (br_taken !== 1'b1) begin
            miss_count++; $display("FAIL rst_br_ge: got %b expected 1", br_taken);
        end
        ex_cond = 4'b1011; #1;
        vec_count++;
        if (br_taken !== 1'b0) begin
            miss_count++; $display("FAIL rst_br_lt: got %b expected 0", br_taken);
        end
        tick();
        idle();
        vec_count++;
        if ({mem_valid, mem_reg_write, mem_result} !== {1'b1, 1'b1, 64'h44}) begin
            miss_count++; $display("FAIL rst_first_capture: got %b/%b/%h expected 1/1/44",
                mem_valid, mem_reg_write, mem_result);
        end
        $display("test_reset_mid_stall: mem_result=%h flags=%b", mem_result, {flag_n, flag_z, flag_v, flag_c});
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_adds_overflow();
        test_branch_cond();
        test_stall();
        test_flush_stall();
        test_invalid();
        test_cond_table();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
